// File: rtl/stream_to_hs_adapter_pkg.sv
// Shared constants and the ap_hs word packing used by the stream/ap_hs adapters.
package stream_to_hs_adapter_pkg;

   localparam int unsigned HS_WIDTH   = 72;
   localparam int unsigned DATA_WIDTH = 64;
   localparam int unsigned ID_WIDTH   = 5;
   localparam int unsigned DATA_LSB   = 8;
   localparam int unsigned TID_LSB    = 2;
   localparam int unsigned TID_WIDTH  = 5;
   localparam int unsigned LAST_BIT   = 0;

   typedef logic [HS_WIDTH-1:0] hs_word_t;

   // Bits 7 and 1 are reserved and always zero.
   function automatic hs_word_t pack_beat(input logic [DATA_WIDTH-1:0] tdata,
                                          input logic [TID_WIDTH-1:0]  tid,
                                          input logic                  tlast);
      hs_word_t word;
      word                          = '0;
      word[DATA_LSB +: DATA_WIDTH]  = tdata;
      word[TID_LSB +: TID_WIDTH]    = tid;
      word[LAST_BIT]                = tlast;
      return word;
   endfunction

endpackage

// File: rtl/stream_to_hs_fifo.sv
// Synchronous FIFO holding packed ap_hs words; read data is zero while empty.
module stream_to_hs_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 72
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == DEPTH_CNT);
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (PTR_W+1)'(1);
            2'b01:   cnt <= cnt - (PTR_W+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: it is only visible through pop_data when count != 0.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/stream_to_hs_adapter.sv
// AXI-Stream to ap_hs input adapter: buffers beats, filters on tdest, packs tid/tlast.
module stream_to_hs_adapter #(
   parameter int unsigned DEPTH      = 2,
   parameter bit          CHECK_DEST = 1'b1
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic [4:0]             accID,
   input  logic [63:0]            inStream_tdata,
   input  logic [4:0]             inStream_tdest,
   input  logic [4:0]             inStream_tid,
   input  logic                   inStream_tlast,
   input  logic                   inStream_tvalid,
   output logic                   inStream_tready,
   output logic [71:0]            out_hs,
   output logic                   out_hs_ap_vld,
   input  logic                   out_hs_ap_ack,
   output logic                   dest_err,
   output logic [$clog2(DEPTH):0] occupancy
);

   import stream_to_hs_adapter_pkg::*;

   logic     full;
   logic     empty;
   logic     accept;
   logic     dest_ok;
   logic     push;
   logic     drop;
   logic     pop;
   hs_word_t packed_word;

   assign inStream_tready = !full;
   assign out_hs_ap_vld   = !empty;

   assign accept  = inStream_tvalid && inStream_tready;
   assign dest_ok = !CHECK_DEST || (inStream_tdest == accID);
   assign push    = accept && dest_ok;
   assign drop    = accept && !dest_ok;
   assign pop     = out_hs_ap_vld && out_hs_ap_ack;

   assign packed_word = pack_beat(inStream_tdata, inStream_tid, inStream_tlast);

   stream_to_hs_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (HS_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (aresetn),
      .push      (push),
      .push_data (packed_word),
      .pop       (pop),
      .pop_data  (out_hs),
      .full      (full),
      .empty     (empty),
      .count     (occupancy)
   );

   // Misdirected beats still complete the handshake so the interconnect never stalls.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         dest_err <= 1'b0;
      end else if (drop) begin
         dest_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_to_hs_adapter.sv
// Directed, table-driven bench for stream_to_hs_adapter (DEPTH=2, both CHECK_DEST settings).
module tb_stream_to_hs_adapter;

   localparam int unsigned DEPTH = 2;

   logic        clk;
   logic        aresetn;
   logic [4:0]  acc_id;
   logic [63:0] tdata;
   logic [4:0]  tdest;
   logic [4:0]  tid;
   logic        tlast;
   logic        tvalid;
   logic        ack;

   logic        tready,    tready_nc;
   logic [71:0] out_hs,    out_hs_nc;
   logic        vld,       vld_nc;
   logic        derr,      derr_nc;
   logic [1:0]  occ,       occ_nc;

   int n_checks = 0;
   int n_pass   = 0;

   stream_to_hs_adapter #(.DEPTH(DEPTH), .CHECK_DEST(1'b1)) dut (
      .clk             (clk),
      .aresetn         (aresetn),
      .accID           (acc_id),
      .inStream_tdata  (tdata),
      .inStream_tdest  (tdest),
      .inStream_tid    (tid),
      .inStream_tlast  (tlast),
      .inStream_tvalid (tvalid),
      .inStream_tready (tready),
      .out_hs          (out_hs),
      .out_hs_ap_vld   (vld),
      .out_hs_ap_ack   (ack),
      .dest_err        (derr),
      .occupancy       (occ)
   );

   stream_to_hs_adapter #(.DEPTH(DEPTH), .CHECK_DEST(1'b0)) dut_nc (
      .clk             (clk),
      .aresetn         (aresetn),
      .accID           (acc_id),
      .inStream_tdata  (tdata),
      .inStream_tdest  (tdest),
      .inStream_tid    (tid),
      .inStream_tlast  (tlast),
      .inStream_tvalid (tvalid),
      .inStream_tready (tready_nc),
      .out_hs          (out_hs_nc),
      .out_hs_ap_vld   (vld_nc),
      .out_hs_ap_ack   (ack),
      .dest_err        (derr_nc),
      .occupancy       (occ_nc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        v;
      logic [63:0] d;
      logic [4:0]  dst;
      logic [4:0]  id;
      logic        l;
      logic        a;
      logic        e_tready;
      logic        e_vld;
      logic [71:0] e_hs;
      logic [1:0]  e_occ;
      logic        e_derr;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

   localparam logic [71:0] A_HS = {64'hDEADBEEF_00000001, 8'h15};
   localparam logic [71:0] B_HS = {64'h00000000_000000B0, 8'h04};
   localparam logic [71:0] C_HS = {64'h00000000_000000C1, 8'h7D};
   localparam logic [71:0] D_HS = {64'h00000000_000000D2, 8'h00};
   localparam logic [71:0] F_HS = {64'h00000000_000000F0, 8'h0D};

   function automatic vec_t mk(input logic v, input logic [63:0] d, input logic [4:0] dst,
                               input logic [4:0] id, input logic l, input logic a,
                               input logic er, input logic ev, input logic [71:0] eh,
                               input logic [1:0] eo, input logic ed);
      vec_t r;
      r.v = v; r.d = d; r.dst = dst; r.id = id; r.l = l; r.a = a;
      r.e_tready = er; r.e_vld = ev; r.e_hs = eh; r.e_occ = eo; r.e_derr = ed;
      return r;
   endfunction

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] dst,
                        input logic [4:0] id, input logic l, input logic a);
      tvalid = v; tdata = d; tdest = dst; tid = id; tlast = l; ack = a;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0);
      aresetn = 1'b0;
      @(negedge clk);
      aresetn = 1'b1;
      step();
   endtask

   function automatic logic [71:0] stream_word(input int j);
      return {64'h1000 + 64'(j), 1'b0, 5'(j), 1'b0, (j == 15)};
   endfunction

   initial begin
      acc_id  = 5'd3;
      aresetn = 1'b0;
      drive(1'b0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0);

      //         v  data                   dst  id    l  a  | rdy vld hs    occ derr
      vecs[0]  = mk(0, 64'h0,                0, 0,  0, 0,   1, 0, 72'h0, 0, 0);
      vecs[1]  = mk(1, 64'hDEADBEEF_00000001, 3, 5,  1, 0,   1, 0, 72'h0, 0, 0);
      vecs[2]  = mk(0, 64'h0,                0, 0,  0, 0,   1, 1, A_HS,  1, 0);
      vecs[3]  = mk(0, 64'h0,                0, 0,  0, 0,   1, 1, A_HS,  1, 0);
      vecs[4]  = mk(0, 64'h0,                0, 0,  0, 1,   1, 1, A_HS,  1, 0);
      vecs[5]  = mk(0, 64'h0,                0, 0,  0, 0,   1, 0, 72'h0, 0, 0);
      vecs[6]  = mk(1, 64'hB0,               3, 1,  0, 0,   1, 0, 72'h0, 0, 0);
      vecs[7]  = mk(1, 64'hC1,               3, 31, 1, 0,   1, 1, B_HS,  1, 0);
      vecs[8]  = mk(1, 64'hD2,               3, 0,  0, 0,   0, 1, B_HS,  2, 0);
      vecs[9]  = mk(1, 64'hD2,               3, 0,  0, 0,   0, 1, B_HS,  2, 0);
      vecs[10] = mk(1, 64'hD2,               3, 0,  0, 1,   0, 1, B_HS,  2, 0);
      vecs[11] = mk(1, 64'hD2,               3, 0,  0, 0,   1, 1, C_HS,  1, 0);
      vecs[12] = mk(0, 64'h0,                0, 0,  0, 1,   0, 1, C_HS,  2, 0);
      vecs[13] = mk(0, 64'h0,                0, 0,  0, 1,   1, 1, D_HS,  1, 0);
      vecs[14] = mk(0, 64'h0,                0, 0,  0, 1,   1, 0, 72'h0, 0, 0);
      vecs[15] = mk(0, 64'h0,                0, 0,  0, 0,   1, 0, 72'h0, 0, 0);
      vecs[16] = mk(1, 64'hE0,               7, 2,  0, 0,   1, 0, 72'h0, 0, 0);
      vecs[17] = mk(0, 64'h0,                0, 0,  0, 0,   1, 0, 72'h0, 0, 1);
      vecs[18] = mk(1, 64'hF0,               3, 3,  1, 0,   1, 0, 72'h0, 0, 1);
      vecs[19] = mk(1, 64'h99,               9, 4,  0, 1,   1, 1, F_HS,  1, 1);
      vecs[20] = mk(0, 64'h0,                0, 0,  0, 0,   1, 0, 72'h0, 0, 1);

      // Outputs while held in reset.
      #2;
      check("rst_tready", 72'(tready), 72'(1'b1));
      check("rst_vld",    72'(vld),    72'(1'b0));
      check("rst_out_hs", out_hs,      72'h0);
      check("rst_occ",    72'(occ),    72'(2'd0));
      check("rst_derr",   72'(derr),   72'(1'b0));
      do_reset();

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].v, vecs[i].d, vecs[i].dst, vecs[i].id, vecs[i].l, vecs[i].a);
         @(negedge clk);
         check($sformatf("vec%0d_tready", i), 72'(tready), 72'(vecs[i].e_tready));
         check($sformatf("vec%0d_vld", i),    72'(vld),    72'(vecs[i].e_vld));
         check($sformatf("vec%0d_out_hs", i), out_hs,      vecs[i].e_hs);
         check($sformatf("vec%0d_occ", i),    72'(occ),    72'(vecs[i].e_occ));
         check($sformatf("vec%0d_derr", i),   72'(derr),   72'(vecs[i].e_derr));
         step();
      end

      // dest_err is sticky only until reset.
      do_reset();
      @(negedge clk);
      check("derr_cleared", 72'(derr), 72'(1'b0));
      step();

      // Misdirected beat: dropped with checking on, delivered with checking off.
      drive(1'b1, 64'h01234567_89ABCDEF, 5'd7, 5'd6, 1'b0, 1'b0);
      @(negedge clk);
      check("drop_tready", 72'(tready), 72'(1'b1));
      step();
      drive(1'b0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      check("drop_occ",     72'(occ),     72'(2'd0));
      check("drop_vld",     72'(vld),     72'(1'b0));
      check("drop_derr",    72'(derr),    72'(1'b1));
      check("nc_occ",       72'(occ_nc),  72'(2'd1));
      check("nc_out_hs",    out_hs_nc,    {64'h01234567_89ABCDEF, 8'h18});
      check("nc_derr",      72'(derr_nc), 72'(1'b0));
      step();

      // Streaming with tvalid and ack held high: one beat per cycle, occupancy 1.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 64'h1000 + 64'(i), 5'd3, 5'(i), (i == 15), 1'b1);
         @(negedge clk);
         check($sformatf("strm%0d_tready", i), 72'(tready), 72'(1'b1));
         if (i == 0) begin
            check("strm0_vld", 72'(vld), 72'(1'b0));
         end else begin
            check($sformatf("strm%0d_vld", i),    72'(vld), 72'(1'b1));
            check($sformatf("strm%0d_out_hs", i), out_hs,   stream_word(i - 1));
            check($sformatf("strm%0d_occ", i),    72'(occ), 72'(2'd1));
         end
         step();
      end
      drive(1'b0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      check("strm_last_out_hs", out_hs, stream_word(15));
      step();
      @(negedge clk);
      check("strm_drained_occ", 72'(occ), 72'(2'd0));
      step();

      // Asynchronous reset mid-cycle with two beats buffered.
      drive(1'b1, 64'hAAAA, 5'd3, 5'd1, 1'b0, 1'b0);
      step();
      drive(1'b1, 64'hBBBB, 5'd3, 5'd2, 1'b0, 1'b0);
      step();
      drive(1'b0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0);
      #2;
      check("pre_arst_occ", 72'(occ), 72'(2'd2));
      aresetn = 1'b0;
      #1;
      check("arst_vld",    72'(vld),    72'(1'b0));
      check("arst_occ",    72'(occ),    72'(2'd0));
      check("arst_tready", 72'(tready), 72'(1'b1));
      check("arst_out_hs", out_hs,      72'h0);
      @(negedge clk);
      aresetn = 1'b1;
      step();
      drive(1'b1, 64'hCAFE_F00D, 5'd3, 5'd9, 1'b1, 1'b0);
      step();
      drive(1'b0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      check("post_arst_occ",    72'(occ), 72'(2'd1));
      check("post_arst_out_hs", out_hs,   {64'h00000000_CAFEF00D, 8'h25});
      step();
      @(negedge clk);
      check("post_arst_empty", 72'(vld), 72'(1'b0));
      check("post_arst_occ0",  72'(occ), 72'(2'd0));
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
